// File: rtl/instr_encoder.sv
// Purpose: encode RV32I field requests into instruction words with IMEM byte addresses, buffered for the loader.
// Latency: a word accepted at edge N is visible at the output head after edge N when the buffer was empty.
// Backpressure: in_ready drops while the buffer is full; a pop frees a slot for the following cycle only.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   clear                 sync flush: empty buffer, reload address, clear err
//   in_valid/in_ready     request handshake; op_kind, rd, rs1, rs2, imm are the request fields
//   out_valid/out_ready   head-word handshake; out_instr, out_addr describe the head word
//   count                 buffer occupancy
//   err                   sticky flag: an illegal op_kind was accepted

// Purpose: generic synchronous FIFO with occupancy count.
// Latency: a word pushed at edge N is at the head after edge N when the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; clear overrides both.
module instr_encoder_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// Purpose: RV32I field-level encoder (ADD, SUB, LW, SW, BEQ, ADDI) feeding an output FIFO.
// Latency: one edge from accept to out_valid when the FIFO is empty.
// Backpressure: in_ready = FIFO not full; head word holds while out_valid & !out_ready.
module instr_encoder #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          IMEM_WORDS = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op_kind,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [12:0]            imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;

  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;

  // Address of the last IMEM word; the next word after it goes back to BASE_ADDR.
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (IMEM_WORDS - 1));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t      push_dat;
  entry_t      head_dat;
  logic [31:0] word;
  logic        legal;
  logic [31:0] addr;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  // Branch offsets are always even; bit 0 of the immediate is never encoded.
  logic unused_imm0;
  assign unused_imm0 = imm[0];

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_kind)
      OP_ADD:  word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_REG};
      OP_SUB:  word = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_REG};
      OP_LW:   word = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      OP_SW:   word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
      OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
      OP_ADDI: word = {imm[11:0], rs1, 3'b000, rd, OPC_IMM};
      default: legal = 1'b0;
    endcase
  end

  // clear wins over everything on its edge, so it also masks push and pop.
  assign in_ready = ~full;
  assign accept   = in_valid & in_ready & ~clear;
  assign push     = accept & legal;
  assign pop      = out_valid & out_ready & ~clear;

  assign push_dat.instr = word;
  assign push_dat.addr  = addr;

  instr_encoder_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Stale FIFO storage is masked so the outputs read zero whenever nothing is valid.
  assign out_valid = ~empty;
  assign out_instr = out_valid ? head_dat.instr : 32'h0;
  assign out_addr  = out_valid ? head_dat.addr  : 32'h0;

  // Only legal pushes consume an address; illegal requests leave it for the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= BASE_ADDR;
    end else if (clear) begin
      addr <= BASE_ADDR;
    end else if (push) begin
      addr <= (addr == LAST_ADDR) ? BASE_ADDR : addr + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (accept & ~legal) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose: self-checking bench for instr_encoder with a queue-based reference model.
// Latency: every bench cycle drives inputs, checks outputs, then advances one clock edge.
// Backpressure: out_ready is driven directly (directed and random) to exercise full/hold cases.
module tb_instr_encoder;

  localparam int          DEPTH      = 4;
  localparam int          IMEM_WORDS = 4;
  localparam logic [31:0] BASE_ADDR  = 32'h0;
  localparam logic [31:0] ADD_X1     = 32'h003100B3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_kind;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [12:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [2:0]  count;
  logic        err;

  always #5 clk = ~clk;

  instr_encoder #(
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE_ADDR),
    .IMEM_WORDS (IMEM_WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_kind   (op_kind),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .count     (count),
    .err       (err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } ent_t;

  ent_t q[$];
  int   widx;
  bit   merr;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Field placement done with shifts and masks on plain integers.
  function automatic bit ref_encode(input int op, input int unsigned rdv, input int unsigned r1,
                                    input int unsigned r2, input int unsigned iv,
                                    output logic [31:0] w);
    int unsigned x;
    x = 0;
    case (op)
      0: x = (r2 << 20) | (r1 << 15) | (rdv << 7) | 'h33;
      1: x = ('h20 << 25) | (r2 << 20) | (r1 << 15) | (rdv << 7) | 'h33;
      2: x = ((iv & 'hFFF) << 20) | (r1 << 15) | (2 << 12) | (rdv << 7) | 'h03;
      3: x = (((iv >> 5) & 'h7F) << 25) | (r2 << 20) | (r1 << 15) | (2 << 12)
             | ((iv & 'h1F) << 7) | 'h23;
      4: x = (((iv >> 12) & 1) << 31) | (((iv >> 5) & 'h3F) << 25) | (r2 << 20) | (r1 << 15)
             | (((iv >> 1) & 'hF) << 8) | (((iv >> 11) & 1) << 7) | 'h63;
      5: x = ((iv & 'hFFF) << 20) | (r1 << 15) | (rdv << 7) | 'h13;
      default: begin
        w = 32'h0;
        return 1'b0;
      end
    endcase
    w = x;
    return 1'b1;
  endfunction

  // Drive one cycle: check outputs against the model, clock, then update the model.
  task automatic cyc(input bit v, input int op, input int r_d, input int r_s1, input int r_s2,
                     input int im, input bit ordy, input bit clr);
    logic [31:0] w;
    bit          legal;
    bit          acc;
    in_valid  = v;
    op_kind   = 3'(op);
    rd        = 5'(r_d);
    rs1       = 5'(r_s1);
    rs2       = 5'(r_s2);
    imm       = 13'(im);
    out_ready = ordy;
    clear     = clr;
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_addr", out_addr, q[0].addr);
    end
    chk("count", count, q.size());
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("err", err, merr);
    legal = ref_encode(op, r_d, r_s1, r_s2, im, w);
    acc   = v && (q.size() != DEPTH);
    @(posedge clk);
    if (clr) begin
      q.delete();
      widx = 0;
      merr = 1'b0;
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) begin
        if (legal) begin
          q.push_back('{w, BASE_ADDR + 32'(4 * widx)});
          widx = (widx + 1) % IMEM_WORDS;
        end else begin
          merr = 1'b1;
        end
      end
    end
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] ei, input logic [31:0] ea);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_instr"}, out_instr, ei);
    chk({tag, "_addr"}, out_addr, ea);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  int op;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_kind = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 13'd0;
    q.delete(); widx = 0; merr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_count", count, 3'd0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // ADD x1,x2,x3
    cyc(1, 0, 1, 2, 3, 0, 0, 0);
    pop_expect("add", ADD_X1, 32'h0);

    // SUB / LW / SW back to back from a fresh address
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 5, 6, 7, 0, 0, 0);
    cyc(1, 2, 5, 2, 0, 8, 0, 0);
    cyc(1, 3, 0, 2, 5, 12, 0, 0);
    pop_expect("sub", 32'h407302B3, 32'h0);
    pop_expect("lw", 32'h00812283, 32'h4);
    pop_expect("sw", 32'h00512623, 32'h8);

    // BEQ x1,x2,+8 and ADDI x1,x0,-1
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 4, 0, 1, 2, 8, 0, 0);
    cyc(1, 5, 1, 0, 0, 'h1FFF, 0, 0);
    pop_expect("beq", 32'h00208463, 32'h0);
    pop_expect("addi", 32'hFFF00093, 32'h4);

    // Fill to DEPTH with the head blocked, then one pop while a request waits
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 5, i + 1, i, 0, i * 3, 0, 0);
    chk("full_count", count, 3'd4);
    chk("full_in_ready", in_ready, 1'b0);
    cyc(1, 5, 9, 9, 0, 77, 1, 0);
    chk("full_pop_count", count, 3'd3);
    chk("full_pop_in_ready", in_ready, 1'b1);
    cyc(1, 5, 9, 9, 0, 77, 0, 0);
    chk("full_refill_count", count, 3'd4);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);

    // Illegal op: sticky err, no push, address reused
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 2, 3, 0, 0, 0);
    cyc(1, 6, 1, 2, 3, 0, 0, 0);
    chk("ill_err", err, 1'b1);
    chk("ill_count", count, 3'd1);
    cyc(1, 0, 1, 2, 3, 0, 0, 0);
    pop_expect("ill_w0", ADD_X1, 32'h0);
    pop_expect("ill_w1", ADD_X1, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_err", err, 1'b0);
    cyc(1, 0, 1, 2, 3, 0, 0, 0);
    pop_expect("clr_addr", ADD_X1, 32'h0);

    // Address wrap after IMEM_WORDS words
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 2, 3, 0, 0, 0);
      pop_expect($sformatf("wrap%0d", i), ADD_X1, 32'(4 * (i % IMEM_WORDS)));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      cyc($urandom_range(0, 9) < 7, op, $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 8191), $urandom_range(0, 9) < 6,
          $urandom_range(0, 49) == 0);
    end

    // Reset in the middle of a stream
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 2, 3, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_count", count, 3'd0);
    q.delete(); widx = 0; merr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 1, 2, 3, 0, 0, 0);
    pop_expect("post_rst", ADD_X1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
